reg_wb_queue: RTL and testbench

//  Writer-side front end for the 32x32 register file: buffers write-back requests

---
 rtl/reg_wb_queue.sv | 121 ++++++++++++
 tb/tb_reg_wb_queue.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_wb_queue.sv
// reg_wb_queue: in-order write-back FIFO draining into the register file port.
// Define WBQ_BYPASS_EN to enable the pending-value bypass lookup.
module reg_wb_queue #(
   parameter int DEPTH = 4,
   parameter int AW    = 2
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          req_valid_i,
   input  logic [4:0]    req_addr_i,
   input  logic [31:0]   req_data_i,
   output logic          req_ready_o,
   input  logic          drain_en_i,
   output logic          RegWrite_o,
   output logic [4:0]    RDaddr_o,
   output logic [31:0]   RDdata_o,
   input  logic [4:0]    RSaddr_i,
   input  logic [4:0]    RTaddr_i,
   output logic          RShit_o,
   output logic [31:0]   RSdata_o,
   output logic          RThit_o,
   output logic [31:0]   RTdata_o,
   output logic [AW:0]   count_o
);

   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [4:0]    addr_mem [DEPTH];
   logic [31:0]   data_mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count_q;
   logic          accept;
   logic          push;
   logic          pop;

   assign req_ready_o = !rst_i && (count_q != FULL);
   assign accept      = req_valid_i && req_ready_o;
   assign push        = accept && (req_addr_i != 5'd0);
   assign pop         = drain_en_i && (count_q != '0);
   assign count_o     = count_q;

   // entry storage; validity comes from count, so no reset needed
   always_ff @(posedge clk_i) begin
      if (push) begin
         addr_mem[wr_ptr] <= req_addr_i;
         data_mem[wr_ptr] <= req_data_i;
      end
   end

   // pointers, occupancy and the registered write-port stage
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count_q    <= '0;
         RegWrite_o <= 1'b0;
         RDaddr_o   <= '0;
         RDdata_o   <= '0;
      end else begin
         RegWrite_o <= pop;
         if (pop) begin
            RDaddr_o <= addr_mem[rd_ptr];
            RDdata_o <= data_mem[rd_ptr];
            rd_ptr   <= rd_ptr + AW'(1);
         end
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         unique case ({push, pop})
            2'b10:   count_q <= count_q + (AW+1)'(1);
            2'b01:   count_q <= count_q - (AW+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

`ifdef WBQ_BYPASS_EN
   logic [AW-1:0] idx;

   // oldest-to-youngest scan so the youngest queued match overrides;
   // the output stage only counts when nothing in the queue matches
   always_comb begin
      RShit_o  = 1'b0;
      RSdata_o = '0;
      RThit_o  = 1'b0;
      RTdata_o = '0;
      idx      = rd_ptr;
      if (RegWrite_o && RSaddr_i != 5'd0 && RDaddr_o == RSaddr_i) begin
         RShit_o  = 1'b1;
         RSdata_o = RDdata_o;
      end
      if (RegWrite_o && RTaddr_i != 5'd0 && RDaddr_o == RTaddr_i) begin
         RThit_o  = 1'b1;
         RTdata_o = RDdata_o;
      end
      for (int i = 0; i < DEPTH; i++) begin
         idx = rd_ptr + AW'(i);
         if ((AW+1)'(i) < count_q) begin
            if (RSaddr_i != 5'd0 && addr_mem[idx] == RSaddr_i) begin
               RShit_o  = 1'b1;
               RSdata_o = data_mem[idx];
            end
            if (RTaddr_i != 5'd0 && addr_mem[idx] == RTaddr_i) begin
               RThit_o  = 1'b1;
               RTdata_o = data_mem[idx];
            end
         end
      end
   end
`else
   logic bypass_unused;

   assign bypass_unused = ^{RSaddr_i, RTaddr_i};
   assign RShit_o  = 1'b0;
   assign RSdata_o = '0;
   assign RThit_o  = 1'b0;
   assign RTdata_o = '0;
`endif

endmodule

// File: tb/tb_reg_wb_queue.sv
// tb_reg_wb_queue: scoreboard bench with a queue-based reference model.
// Directed scenarios followed by randomized traffic and resets.
module tb_reg_wb_queue;

   localparam int DEPTH = 4;
   localparam int AW    = 2;

   typedef struct {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   logic          clk = 1'b0;
   logic          rst_i;
   logic          req_valid_i;
   logic [4:0]    req_addr_i;
   logic [31:0]   req_data_i;
   logic          req_ready_o;
   logic          drain_en_i;
   logic          RegWrite_o;
   logic [4:0]    RDaddr_o;
   logic [31:0]   RDdata_o;
   logic [4:0]    RSaddr_i;
   logic [4:0]    RTaddr_i;
   logic          RShit_o;
   logic [31:0]   RSdata_o;
   logic          RThit_o;
   logic [31:0]   RTdata_o;
   logic [AW:0]   count_o;

   int tests = 0;
   int fails = 0;

   ent_t model_q[$];
   ent_t exp_wr[$];
   logic out_v = 1'b0;
   ent_t out_e;

   reg_wb_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_addr_i(req_addr_i),
      .req_data_i(req_data_i), .req_ready_o(req_ready_o),
      .drain_en_i(drain_en_i), .RegWrite_o(RegWrite_o),
      .RDaddr_o(RDaddr_o), .RDdata_o(RDdata_o),
      .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i),
      .RShit_o(RShit_o), .RSdata_o(RSdata_o),
      .RThit_o(RThit_o), .RTdata_o(RTdata_o),
      .count_o(count_o)
   );

   always #5 clk = ~clk;

   function automatic void look(input logic [4:0] a,
                                output logic hit,
                                output logic [31:0] d);
      hit = 1'b0;
      d   = '0;
`ifdef WBQ_BYPASS_EN
      if (a != 5'd0) begin
         if (out_v && out_e.a == a) begin
            hit = 1'b1;
            d   = out_e.d;
         end
         foreach (model_q[i]) begin
            if (model_q[i].a == a) begin
               hit = 1'b1;
               d   = model_q[i].d;
            end
         end
      end
`endif
   endfunction

   // scoreboard monitor: every write strobe must match the next expected pop
   always @(negedge clk) begin
      if (RegWrite_o) begin
         ent_t e;
         tests++;
         if (exp_wr.size() == 0) begin
            fails++;
            $display("FAIL wr_unexpected: got strobe a=%0d d=%h, required none",
                     RDaddr_o, RDdata_o);
         end else begin
            e = exp_wr.pop_front();
            if (RDaddr_o !== e.a || RDdata_o !== e.d) begin
               fails++;
               $display("FAIL wr_order: got a=%0d d=%h, required a=%0d d=%h",
                        RDaddr_o, RDdata_o, e.a, e.d);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] req);
      tests++;
      if (got !== req) begin
         fails++;
         $display("FAIL %s: got %h, required %h", nm, got, req);
      end
   endtask

   task automatic cycle(input logic rst, input logic v,
                        input logic [4:0] a, input logic [31:0] d,
                        input logic dr, input logic [4:0] rs,
                        input logic [4:0] rt);
      logic        hs, ht, rdy, psh, pp;
      logic [31:0] ds, dt;
      ent_t        e;
      @(negedge clk);
      rst_i       = rst;
      req_valid_i = v;
      req_addr_i  = a;
      req_data_i  = d;
      drain_en_i  = dr;
      RSaddr_i    = rs;
      RTaddr_i    = rt;
      #1;
      rdy = !rst && (model_q.size() != DEPTH);
      chk("ready", {31'd0, req_ready_o}, {31'd0, rdy});
      chk("count", {29'd0, count_o}, model_q.size());
      look(rs, hs, ds);
      look(rt, ht, dt);
      chk("rs_hit", {31'd0, RShit_o}, {31'd0, hs});
      chk("rs_data", RSdata_o, ds);
      chk("rt_hit", {31'd0, RThit_o}, {31'd0, ht});
      chk("rt_data", RTdata_o, dt);
      if (rst) begin
         model_q.delete();
         out_v = 1'b0;
      end else begin
         pp  = dr && (model_q.size() != 0);
         psh = v && rdy && (a != 5'd0);
         out_v = pp;
         if (pp) begin
            out_e = model_q.pop_front();
            exp_wr.push_back(out_e);
         end
         if (psh) begin
            e.a = a;
            e.d = d;
            model_q.push_back(e);
         end
      end
      @(posedge clk);
   endtask

   initial begin
      rst_i = 1'b1; req_valid_i = 1'b0; req_addr_i = '0; req_data_i = '0;
      drain_en_i = 1'b0; RSaddr_i = '0; RTaddr_i = '0;
      cycle(1, 0, 0, 0, 0, 0, 0);
      cycle(1, 0, 0, 0, 0, 0, 0);
      // 1: single entry, bypass, then drain
      cycle(0, 1, 5, 32'hDEADBEEF, 0, 5, 0);
      cycle(0, 0, 0, 0, 0, 5, 5);
      cycle(0, 0, 0, 0, 1, 5, 0);
      cycle(0, 0, 0, 0, 0, 5, 5);
      cycle(0, 0, 0, 0, 0, 5, 5);
      // 2: fill to full, refuse, then push+pop at count 3
      for (int i = 0; i < 5; i++)
         cycle(0, 1, 5'(i + 10), 32'(i + 100), 0, 5'(i + 10), 10);
      cycle(0, 0, 0, 0, 1, 11, 12);
      cycle(0, 1, 20, 32'h20, 1, 20, 12);
      for (int i = 0; i < 5; i++)
         cycle(0, 0, 0, 0, 1, 13, 20);
      // 3: same register twice, youngest wins through drain
      cycle(0, 1, 7, 32'h1, 0, 0, 7);
      cycle(0, 1, 7, 32'h2, 0, 0, 7);
      for (int i = 0; i < 5; i++)
         cycle(0, 0, 0, 0, 1, 7, 7);
      // 4: $0 write is accepted but discarded
      cycle(0, 1, 0, 32'h55, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0);
      // 5: reset with entries pending
      for (int i = 0; i < 3; i++)
         cycle(0, 1, 5'(i + 3), 32'(i), 0, 4, 5);
      cycle(1, 1, 9, 32'h9, 1, 4, 5);
      cycle(0, 0, 0, 0, 1, 4, 5);
      cycle(0, 0, 0, 0, 1, 4, 5);
      // 6: back-to-back push/pop pairs across pointer wrap
      for (int i = 1; i <= 10; i++)
         cycle(0, 1, 5'(i), 32'(i * 16), 1, 5'(i), 5'(i - 1));
      cycle(0, 0, 0, 0, 1, 10, 9);
      cycle(0, 0, 0, 0, 1, 10, 9);
      // random traffic, small address range for frequent hits
      for (int n = 0; n < 800; n++)
         cycle(($urandom_range(0, 60) == 0),
               1'($urandom_range(0, 1)),
               5'($urandom_range(0, 7)), $urandom(),
               ($urandom_range(0, 2) != 0),
               5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      for (int n = 0; n < 8; n++)
         cycle(0, 0, 0, 0, 1, 0, 0);
      @(negedge clk);
      chk("drained", exp_wr.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
